// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC, drives the instruction-memory
// address and loads the IF/ID register feeding decode.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stall             hold PC and IF/ID (load-use hazard)
//   redirect,
//   redirect_pc       taken branch/jump: flush IF/ID, retarget PC
//   imem_addr         instruction address (combinational from PC)
//   imem_req          fetch request, 1 whenever out of reset
//   imem_ready,
//   imem_rdata        wait-state memory response
//   if_id_instr,
//   if_id_pc_plus4,
//   if_id_valid       IF/ID register outputs
//   fetch_misalign    one-cycle flag for a misaligned redirect target
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   -> misaligned redirect targets are forced to word
//                alignment and fetch_misalign pulses for one cycle
//   undefined -> redirect_pc used as given, fetch_misalign tied 0

module adder32 (
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] sum
);
    assign sum = add_a + add_b;
endmodule

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_misalign
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        req_q;

    // Carry out is dropped: 32'hFFFF_FFFC + 4 wraps to 0.
    adder32 u_pc_add (
        .add_a (pc),
        .add_b (32'd4),
        .sum   (pc_plus4)
    );

`ifdef ALIGN_CHECK_EN
    logic redir_mis;
    logic mis_q;

    assign redir_tgt = {redirect_pc[31:2], 2'b00};
    assign redir_mis = |redirect_pc[1:0];

    // Cleared on every edge unless a misaligned redirect occurs,
    // so the flag is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= redirect & redir_mis;
        end
    end

    assign fetch_misalign = mis_q;
`else
    assign redir_tgt      = redirect_pc;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            req_q          <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            req_q <= 1'b1;
            // Redirect outranks stall; any returned word is dropped.
            if (redirect) begin
                pc          <= redir_tgt;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (stall) begin
                pc          <= pc;
            end else if (imem_ready) begin
                pc             <= pc_plus4;
                if_id_instr    <= imem_rdata;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end else begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign imem_req  = req_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a
// randomized run compared against a behavioural fetch model.

module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_misalign;

    int tests;
    int fails;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p4;
    logic        m_valid;
    logic        m_mis;

    localparam logic [31:0] NOP = 32'h0000_0000;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs and advance the model by the
    // fetch rules; outputs are then stable 1ns after the edge.
    task automatic step(input logic r, input logic [31:0] rpc,
                        input logic s, input logic rdy,
                        input logic [31:0] data);
        @(negedge clk);
        redirect    = r;
        redirect_pc = rpc;
        stall       = s;
        imem_ready  = rdy;
        imem_rdata  = data;
        @(posedge clk);
        m_mis = 1'b0;
        if (r) begin
`ifdef ALIGN_CHECK_EN
            m_pc  = rpc & 32'hFFFF_FFFC;
            m_mis = (rpc % 4) != 0;
`else
            m_pc  = rpc;
`endif
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (s) begin
            // hold everything
        end else if (rdy) begin
            m_p4    = m_pc + 32'd4;
            m_pc    = m_p4;
            m_instr = data;
            m_valid = 1'b1;
        end else begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'd0;
        m_pc = 32'd0; m_instr = NOP; m_p4 = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({imem_req, if_id_valid, fetch_misalign} !== 3'b000 ||
            imem_addr !== 32'd0 || if_id_instr !== NOP ||
            if_id_pc_plus4 !== 32'd0) begin
            fails++;
            $display("FAIL reset_vals: req=%b v=%b mis=%b addr=%h i=%h p4=%h need 0s",
                     imem_req, if_id_valid, fetch_misalign, imem_addr,
                     if_id_instr, if_id_pc_plus4);
        end
        do_reset();
        tests++;
        if (imem_req !== 1'b1) begin
            fails++;
            $display("FAIL req_after_reset: got %b need 1", imem_req);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (imem_addr !== 32'(i * 4)) begin
                fails++;
                $display("FAIL seq_addr%0d: got %h need %h", i, imem_addr, i * 4);
            end
            step(1'b0, 32'd0, 1'b0, 1'b1, words[i]);
            tests++;
            if (if_id_pc_plus4 !== 32'(i * 4 + 4) || if_id_valid !== 1'b1 ||
                if_id_instr !== words[i]) begin
                fails++;
                $display("FAIL seq_out%0d: p4=%h v=%b i=%h need %h 1 %h", i,
                         if_id_pc_plus4, if_id_valid, if_id_instr,
                         i * 4 + 4, words[i]);
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_0000);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_0004);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);
            tests++;
            if (imem_addr !== 32'd8 || if_id_valid !== 1'b0) begin
                fails++;
                $display("FAIL wait%0d: addr=%h v=%b need 8 0", i,
                         imem_addr, if_id_valid);
            end
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_0008);
        tests++;
        if (if_id_pc_plus4 !== 32'd12 || if_id_valid !== 1'b1 ||
            if_id_instr !== 32'h1111_0008) begin
            fails++;
            $display("FAIL wait_deliver: p4=%h v=%b i=%h need c 1 11110008",
                     if_id_pc_plus4, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_stall();
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'hBAD0_BAD0);
        tests++;
        if (imem_addr !== 32'd12 || if_id_pc_plus4 !== 32'd12 ||
            if_id_valid !== 1'b1 || if_id_instr !== 32'h1111_0008) begin
            fails++;
            $display("FAIL stall_hold: addr=%h p4=%h v=%b i=%h need c c 1 11110008",
                     imem_addr, if_id_pc_plus4, if_id_valid, if_id_instr);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_000C);
        tests++;
        if (if_id_pc_plus4 !== 32'd16 || if_id_instr !== 32'h1111_000C ||
            imem_addr !== 32'd16) begin
            fails++;
            $display("FAIL stall_refetch: p4=%h i=%h addr=%h need 10 1111000c 10",
                     if_id_pc_plus4, if_id_instr, imem_addr);
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h5555_5555);
        tests++;
        if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 ||
            if_id_instr !== NOP) begin
            fails++;
            $display("FAIL redir: addr=%h v=%b i=%h need 100 0 0",
                     imem_addr, if_id_valid, if_id_instr);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h7777_0100);
        tests++;
        if (if_id_pc_plus4 !== 32'h104 || if_id_valid !== 1'b1) begin
            fails++;
            $display("FAIL redir_fetch: p4=%h v=%b need 104 1",
                     if_id_pc_plus4, if_id_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h9999_FFFC);
        tests++;
        if (imem_addr !== 32'd0 || if_id_pc_plus4 !== 32'd0 ||
            if_id_valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap: addr=%h p4=%h v=%b need 0 0 1",
                     imem_addr, if_id_pc_plus4, if_id_valid);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h9999_0000);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_addr !== 32'd0 || if_id_valid !== 1'b0 ||
            if_id_pc_plus4 !== 32'd0 || imem_req !== 1'b0 ||
            if_id_instr !== NOP) begin
            fails++;
            $display("FAIL midwait_reset: addr=%h v=%b p4=%h req=%b i=%h need 0s",
                     imem_addr, if_id_valid, if_id_pc_plus4, imem_req,
                     if_id_instr);
        end
        do_reset();
        tests++;
        if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_pc: addr=%h req=%b need 0 1",
                     imem_addr, imem_req);
        end
    endtask

    task automatic test_align();
        step(1'b1, 32'h0000_0102, 1'b0, 1'b1, 32'd0);
        tests++;
`ifdef ALIGN_CHECK_EN
        if (imem_addr !== 32'h100 || fetch_misalign !== 1'b1 ||
            if_id_valid !== 1'b0) begin
            fails++;
            $display("FAIL align: addr=%h mis=%b v=%b need 100 1 0",
                     imem_addr, fetch_misalign, if_id_valid);
        end
`else
        if (imem_addr !== 32'h102 || fetch_misalign !== 1'b0 ||
            if_id_valid !== 1'b0) begin
            fails++;
            $display("FAIL align: addr=%h mis=%b v=%b need 102 0 0",
                     imem_addr, fetch_misalign, if_id_valid);
        end
`endif
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tests++;
        if (fetch_misalign !== 1'b0) begin
            fails++;
            $display("FAIL align_pulse: mis=%b need 0", fetch_misalign);
        end
    endtask

    task automatic test_random();
        logic        r, s, rdy;
        logic [31:0] rpc, data;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 9) == 0);
            s    = ($urandom_range(0, 4) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            rpc  = $urandom;
            if ($urandom_range(0, 1) == 1) rpc[1:0] = 2'b00;
            data = $urandom;
            step(r, rpc, s, rdy, data);
            tests++;
            if (imem_addr !== m_pc || if_id_instr !== m_instr ||
                if_id_pc_plus4 !== m_p4 || if_id_valid !== m_valid ||
                fetch_misalign !== m_mis || imem_req !== 1'b1) begin
                fails++;
                $display("FAIL rand%0d: addr=%h i=%h p4=%h v=%b mis=%b need %h %h %h %b %b",
                         i, imem_addr, if_id_instr, if_id_pc_plus4,
                         if_id_valid, fetch_misalign,
                         m_pc, m_instr, m_p4, m_valid, m_mis);
            end
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'd0;
        m_pc = 32'd0; m_instr = NOP; m_p4 = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_redirect();
        test_wrap_and_reset();
        test_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
